// File: rtl/product_bcd.sv
// Converts a 16-bit multiplier product into sign plus five BCD digits using a
// serial double-dabble engine with a fixed 20-cycle busy window per request.
module product_bcd #(
  parameter bit SIGNED_MODE = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Product,
  output logic        Busy,
  output logic        Done,
  output logic        Neg,
  output logic [19:0] Digits
);

  typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

  // Iterations use counter values 0..16; the cycle with the counter at 17
  // commits the finished scratch to the outputs.
  localparam logic [4:0] LAST_ITER = 5'd16;
  localparam logic [4:0] COMMIT    = LAST_ITER + 5'd1;

  state_t      state, next_state;
  logic [15:0] prod;
  logic [19:0] scratch;
  logic [16:0] mag;
  logic [4:0]  cnt;
  logic        sign;
  logic [36:0] dd_next;

  function automatic logic [19:0] add3(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (Start) next_state = LOAD;
      LOAD: next_state = CONV;
      CONV: if (cnt == COMMIT) next_state = DONE;
      DONE: next_state = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE);
  end

  always_comb begin
    dd_next = {add3(scratch), mag} << 1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prod    <= '0;
      scratch <= '0;
      mag     <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      Neg     <= 1'b0;
      Digits  <= '0;
    end else begin
      unique case (state)
        IDLE: if (Start) prod <= Product;
        LOAD: begin
          sign    <= SIGNED_MODE && prod[15];
          // 17-bit negation keeps 16'h8000 representable as +32768.
          mag     <= (SIGNED_MODE && prod[15]) ? (~{1'b1, prod} + 17'd1)
                                               : {1'b0, prod};
          scratch <= '0;
          cnt     <= '0;
        end
        CONV: begin
          if (cnt == COMMIT) begin
            Digits <= scratch;
            Neg    <= sign;
          end else begin
            {scratch, mag} <= dd_next;
            cnt            <= cnt + 5'd1;
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd.sv
// Directed bench for product_bcd: signed and unsigned instances share stimulus,
// expected values are hand-computed constants.
module tb_product_bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] product;
  logic        busy_s, done_s, neg_s;
  logic [19:0] digits_s;
  logic        busy_u, done_u, neg_u;
  logic [19:0] digits_u;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_bcd #(.SIGNED_MODE(1'b1)) dut_s (
    .Clk(clk), .Reset(reset), .Start(start), .Product(product),
    .Busy(busy_s), .Done(done_s), .Neg(neg_s), .Digits(digits_s)
  );

  product_bcd #(.SIGNED_MODE(1'b0)) dut_u (
    .Clk(clk), .Reset(reset), .Start(start), .Product(product),
    .Busy(busy_u), .Done(done_u), .Neg(neg_u), .Digits(digits_u)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request; n counts negedges after the accepting edge k. Busy must be
  // high for n = 0..19 and Done only at n = 19. With dbl set, a second
  // request is presented to edge k+5 and must be ignored.
  task automatic do_conv(input logic [15:0] p, input logic [19:0] exp_s,
                         input logic exp_neg_s, input logic [19:0] exp_u,
                         input logic dbl);
    int bad;
    bad = 0;
    @(negedge clk); start = 1'b1; product = p;
    @(negedge clk); start = 1'b0; product = ~p;
    for (int n = 0; n <= 22; n++) begin
      if (n > 0) @(negedge clk);
      if (busy_s !== (n <= 19) || busy_u !== (n <= 19)) bad++;
      if (done_s !== (n == 19) || done_u !== (n == 19)) bad++;
      if (n == 19) begin
        check($sformatf("digits_s %h", p), digits_s, exp_s);
        check($sformatf("neg_s %h", p), neg_s, exp_neg_s);
        check($sformatf("digits_u %h", p), digits_u, exp_u);
        check($sformatf("neg_u %h", p), neg_u, 1'b0);
      end
      if (dbl && n == 4) begin start = 1'b1; product = 16'h0001; end
      if (dbl && n == 5) start = 1'b0;
    end
    check($sformatf("timing %h", p), bad, 0);
  endtask

  initial begin
    int bad, pulses, last, idle_cnt;

    reset = 1'b1; start = 1'b0; product = 16'h0000;
    #2;
    check("rst busy", {busy_s, busy_u}, 2'b00);
    check("rst done", {done_s, done_u}, 2'b00);
    check("rst neg", {neg_s, neg_u}, 2'b00);
    check("rst digits_s", digits_s, 20'h00000);
    check("rst digits_u", digits_u, 20'h00000);
    @(negedge clk); @(negedge clk); reset = 1'b0;

    do_conv(16'h3039, 20'h12345, 1'b0, 20'h12345, 1'b0);
    do_conv(16'hFFFF, 20'h00001, 1'b1, 20'h65535, 1'b0);
    do_conv(16'h8000, 20'h32768, 1'b1, 20'h32768, 1'b0);

    // Abort mid-conversion: reset at edge k+8.
    @(negedge clk); start = 1'b1; product = 16'h0064;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    check("hold digits_s", digits_s, 20'h32768);
    check("hold neg_s", neg_s, 1'b1);
    check("busy mid", busy_s, 1'b1);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort busy", {busy_s, busy_u}, 2'b00);
    check("abort done", {done_s, done_u}, 2'b00);
    check("abort neg_s", neg_s, 1'b0);
    check("abort digits_s", digits_s, 20'h00000);
    check("abort digits_u", digits_u, 20'h00000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done_s !== 1'b0 || busy_s !== 1'b0) bad++;
    end
    check("no done after abort", bad, 0);

    do_conv(16'h0007, 20'h00007, 1'b0, 20'h00007, 1'b0);
    do_conv(16'h0000, 20'h00000, 1'b0, 20'h00000, 1'b0);
    do_conv(16'h0064, 20'h00100, 1'b0, 20'h00100, 1'b1);

    // Start held high: back-to-back conversions every 21 cycles.
    @(negedge clk); start = 1'b1; product = 16'h04D2;
    pulses = 0; last = -1; idle_cnt = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (!busy_s) idle_cnt++;
      if (done_s) begin
        pulses++;
        check("held digits", digits_s, 20'h01234);
        if (last >= 0) begin
          check("held period", c - last, 21);
          check("held idle gap", idle_cnt, 1);
        end
        last = c;
        idle_cnt = 0;
      end
    end
    check("held pulses", pulses, 3);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check("idle at end", {busy_s, busy_u}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_bcd.md
PRODUCT_BCD -- requirements
Module: product_bcd

Interface
REQ-001 The block SHALL have parameter SIGNED_MODE, default 1: 1 = Product is two's complement, 0 = Product is unsigned.
REQ-002 The block SHALL have port Clk  input  1  system clock, all state updates on rising edge.
REQ-003 The block SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port Start  input  1  conversion request, sampled on Clk, synchronous, active-high.
REQ-005 The block SHALL have port Product  input  16  multiplier result {A register, B register}, captured when Start is accepted.
REQ-006 The block SHALL have port Busy  output  1  high from acceptance of Start until the Done cycle inclusive.
REQ-007 The block SHALL have port Done  output  1  single-cycle pulse marking that Digits and Neg are updated.
REQ-008 The block SHALL have port Neg  output  1  sign of the last converted value.
REQ-009 The block SHALL have port Digits  output  20  five BCD digits of the magnitude; [19:16] = ten-thousands ... [3:0] = ones.

Function
REQ-010 The block SHALL implement the states IDLE, LOAD, CONV and DONE.
REQ-011 In IDLE with Start=1 at a rising edge, the block SHALL capture Product into an internal register and enter LOAD.
REQ-012 In LOAD, the block SHALL form the magnitude and go to CONV on the next edge.
- Magnitude when SIGNED_MODE=1 and Product[15]=1: 17-bit two's-complement negation of Product.
- Magnitude otherwise: Product zero-extended to 17 bits.
- In the same edge, the block SHALL clear the BCD scratch register and the iteration counter.
REQ-013 In CONV, the block SHALL perform one double-dabble iteration per cycle, for exactly 17 iterations (counter 0..16).
- Each iteration: add 3 to every scratch digit >= 5, then shift the {scratch, magnitude} register left by one.
REQ-014 After the iteration with counter=16, the block SHALL enter DONE and load the scratch register into Digits and the sign into Neg.
REQ-015 In DONE, the block SHALL assert Done for exactly one cycle and return to IDLE on the next edge.
REQ-016 The latency SHALL be fixed.
- Start accepted at edge k.
- Done high during the cycle following edge k+19.
- Busy high following edges k through k+19.
REQ-017 Digits and Neg SHALL hold their values at all times except the DONE-entry update.
REQ-018 Start SHALL be ignored in LOAD, CONV and DONE; no queuing; Product changes after capture SHALL have no effect.
REQ-019 Start held high continuously SHALL cause back-to-back conversions, each accepted in the first IDLE cycle.
REQ-020 Boundary values SHALL convert exactly.
- 16'h8000 with SIGNED_MODE=1 -> Neg=1, magnitude 32768.
- 16'h0000 -> Neg=0, Digits 00000; negative zero is not possible.
REQ-021 When SIGNED_MODE=0, Neg SHALL always be 0, and 16'hFFFF SHALL yield 65535.
REQ-022 Every BCD digit in Digits SHALL be in the range 0..9.

Reset
REQ-023 While Reset=1, the block SHALL immediately force the following, independent of Clk:
- state IDLE;
- Busy=0, Done=0, Neg=0, Digits=20'h00000;
- counter and scratch registers cleared.
REQ-024 Reset asserted mid-conversion SHALL abort that conversion with no Done pulse; the first Start after deassertion SHALL be accepted normally.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- SIGNED_MODE=1, Product=16'h3039, Start pulse -> after fixed latency, one Done pulse, Neg=0, Digits=20'h12345.
- SIGNED_MODE=1, Product=16'hFFFF -> Neg=1, Digits=20'h00001; then 16'h8000 -> Neg=1, Digits=20'h32768.
- SIGNED_MODE=0, Product=16'hFFFF -> Neg=0, Digits=20'h65535; Product=16'h0000 -> Digits=20'h00000.
- Start at edge k with 16'h0064, Start again at k+5 with 16'h0001 -> single Done with Digits=20'h00100; second request ignored.
- Reset asserted at edge k+8 of a conversion -> outputs zero immediately, no Done; Start after release with 16'h0007 -> Digits=20'h00007.
- Start held high with 16'h04D2 -> Done pulses every 21 cycles, Digits=20'h01234 each time, Busy low exactly one cycle between conversions.
